// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared definitions for the quadrature step decoder.
//   - Phase constants, packed as {A, B}
//   - Direction encoding used on the counter's up_down input
//   - Detent accumulator limits (used when DETENT_MODE_EN is defined)
//   - is_fwd / is_rev: classify a single-bit phase change
// -----------------------------------------------------------------------------
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic signed [2:0] DETENT_Q_MAX = 3'sd3;
    localparam logic signed [2:0] DETENT_Q_MIN = -3'sd3;

    // Forward order is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic is_fwd(input logic [1:0] prev, input logic [1:0] cur);
        logic r;
        case (prev)
            PH_00:   r = (cur == PH_10);
            PH_10:   r = (cur == PH_11);
            PH_11:   r = (cur == PH_01);
            default: r = (cur == PH_00);
        endcase
        return r;
    endfunction

    function automatic logic is_rev(input logic [1:0] prev, input logic [1:0] cur);
        logic r;
        case (prev)
            PH_00:   r = (cur == PH_01);
            PH_01:   r = (cur == PH_11);
            PH_11:   r = (cur == PH_10);
            default: r = (cur == PH_00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// -----------------------------------------------------------------------------
// quad_debounce
// One encoder channel: two-flop synchronizer followed by a stable-count filter.
// The filtered value follows the synchronized input only after the input has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports
//   clk        in   system clock
//   reset_n    in   synchronous reset, active-low
//   pin_i      in   raw asynchronous pin
//   filt_o     out  debounced level
//   settled_o  out  synchronized input equals the debounced level
// -----------------------------------------------------------------------------
module quad_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int DB_W            = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic filt_o,
    output logic settled_o
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            filt_q;
    logic            filt_d;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            // Last mismatching cycle of the window: accept the new level and
            // leave the counter cleared.
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o    = filt_q;
    assign settled_o = (sync2_q == filt_q);

endmodule

// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
// Turns a bouncy mechanical quadrature encoder into one-cycle count commands
// for the up/down display counter.
//
// Ports
//   clk       in   system clock
//   reset_n   in   synchronous reset, active-low
//   quad_a    in   encoder channel A, asynchronous
//   quad_b    in   encoder channel B, asynchronous
//   enable_n  out  step strobe, low for one cycle per step
//   up_down   out  direction of the last step (0 = up, 1 = down)
//   err       out  one-cycle pulse when both channels change together
//
// Build option
//   DETENT_MODE_EN  when defined, sub-steps are accumulated and a single
//                   command is issued per full detent (on the return to 00).
//                   When undefined every legal transition is a step.
// -----------------------------------------------------------------------------
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int DB_W            = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic quad_a,
    input  logic quad_b,
    output logic enable_n,
    output logic up_down,
    output logic err
);

    logic       filt_a;
    logic       filt_b;
    logic       settled_a;
    logic       settled_b;

    logic [1:0] cur;
    logic [1:0] prev_q;
    logic       primed_q;
    logic       primed_d;
    logic [1:0] flush_q;
    logic       enable_n_q;
    logic       up_down_q;
    logic       err_q;
    logic       step;
    logic       step_dir;
    logic       both_chg;

`ifdef DETENT_MODE_EN
    logic signed [2:0] q_q;
    logic signed [2:0] q_d;
`endif

    quad_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_deb_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .pin_i     (quad_a),
        .filt_o    (filt_a),
        .settled_o (settled_a)
    );

    quad_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_deb_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .pin_i     (quad_b),
        .filt_o    (filt_b),
        .settled_o (settled_b)
    );

    always_comb begin
        cur      = {filt_a, filt_b};
        both_chg = primed_q && ((cur ^ prev_q) == 2'b11);
        step     = 1'b0;
        step_dir = up_down_q;

        // The synchronizers still hold their reset zeros for two cycles after
        // release; flush_q keeps priming from latching onto those stale values
        // so a resting position of 11 is not mistaken for a real transition.
        primed_d = primed_q | (flush_q[1] & settled_a & settled_b);

`ifdef DETENT_MODE_EN
        q_d = q_q;
        if (primed_q) begin
            if (both_chg) begin
                q_d = '0;
            end else if (is_fwd(prev_q, cur)) begin
                if (cur == PH_00) begin
                    step     = (q_q == DETENT_Q_MAX);
                    step_dir = DIR_UP;
                    q_d      = '0;
                end else begin
                    q_d = q_q + 3'sd1;
                end
            end else if (is_rev(prev_q, cur)) begin
                if (cur == PH_00) begin
                    step     = (q_q == DETENT_Q_MIN);
                    step_dir = DIR_DOWN;
                    q_d      = '0;
                end else begin
                    q_d = q_q - 3'sd1;
                end
            end
        end
`else
        if (primed_q) begin
            if (is_fwd(prev_q, cur)) begin
                step     = 1'b1;
                step_dir = DIR_UP;
            end else if (is_rev(prev_q, cur)) begin
                step     = 1'b1;
                step_dir = DIR_DOWN;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flush_q    <= 2'b00;
            primed_q   <= 1'b0;
            prev_q     <= PH_00;
            enable_n_q <= 1'b1;
            up_down_q  <= DIR_UP;
            err_q      <= 1'b0;
`ifdef DETENT_MODE_EN
            q_q        <= '0;
`endif
        end else begin
            flush_q    <= {flush_q[0], 1'b1};
            primed_q   <= primed_d;
            prev_q     <= cur;
            enable_n_q <= ~step;
            if (step) begin
                up_down_q <= step_dir;
            end
            err_q      <= both_chg;
`ifdef DETENT_MODE_EN
            q_q        <= q_d;
`endif
        end
    end

    assign enable_n = enable_n_q;
    assign up_down  = up_down_q;
    assign err      = err_q;

endmodule
